// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : N-operand bypass selection against M producer stages (nearest
//            first), per-register scoreboard for variable-latency producers,
//            ID stall generation and a sticky stall watchdog.
//            Optional macro FWD_PERF_EN adds perf_fwd / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
   parameter int NREAD  = 2,
   parameter int NSTAGE = 2,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32,
   parameter int WDOG   = 255
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic [NREAD*REG_W-1:0]                 rd_reg,
   input  logic [NREAD*DATA_W-1:0]                rd_rfdat,
   input  logic [NSTAGE*REG_W-1:0]                st_dest,
   input  logic [NSTAGE-1:0]                      st_wen,
   input  logic [NSTAGE-1:0]                      st_valid,
   input  logic [NSTAGE*DATA_W-1:0]               st_data,
   input  logic                                   iss_en,
   input  logic [REG_W-1:0]                       iss_reg,
   input  logic                                   cmp_en,
   input  logic [REG_W-1:0]                       cmp_reg,
   output logic [NREAD*DATA_W-1:0]                fwd_data,
   output logic [NREAD*$clog2(NSTAGE+1)-1:0]      fwd_sel,
   output logic                                   stall,
   output logic [(2**REG_W)-1:0]                  sb_busy,
`ifdef FWD_PERF_EN
   output logic [31:0]                            perf_fwd,
   output logic [31:0]                            perf_stall,
`endif
   output logic                                   wdog_err
);

   localparam int         c_NREGS = 2**REG_W;
   localparam int         c_SELW  = $clog2(NSTAGE+1);
   localparam logic [7:0] c_wdog  = 8'(WDOG);

   logic [c_NREGS-1:0] r_sb;
   logic [7:0]         r_stall_cnt;
   logic [7:0]         w_cnt_nxt;
   logic               r_wdog_err;
   logic [NREAD-1:0]   w_op_stall;
   logic [NREAD-1:0]   w_op_fwd;

   // ------------------------------------------------------------------------
   // Per-operand source resolution
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NREAD; gi++) begin : g_op
      logic [REG_W-1:0]  w_src;
      logic              w_hit;
      logic              w_valid;
      logic [DATA_W-1:0] w_sdata;
      logic [c_SELW-1:0] w_sel;
      logic              w_nz;
      logic              w_fwd;
      logic              w_hazard;
      logic              w_bypass;

      assign w_src = rd_reg[gi*REG_W +: REG_W];
      assign w_nz  = (w_src != '0);

      // Scan oldest to youngest so the youngest matching stage overrides;
      // only the nearest match is ever used, even if it is not yet valid.
      always_comb begin
         w_hit   = 1'b0;
         w_valid = 1'b0;
         w_sdata = '0;
         w_sel   = '0;
         for (int k = NSTAGE-1; k >= 0; k--) begin
            if (st_wen[k] && (st_dest[k*REG_W +: REG_W] == w_src)) begin
               w_hit   = 1'b1;
               w_valid = st_valid[k];
               w_sdata = st_data[k*DATA_W +: DATA_W];
               w_sel   = c_SELW'(k + 1);
            end
         end
      end

      assign w_fwd    = w_nz & w_hit & w_valid;
      assign w_hazard = w_nz & w_hit & ~w_valid;
      // A completing long-latency result is delivered through a stage this
      // same cycle, so the busy bit must not hold ID.
      assign w_bypass = cmp_en & (cmp_reg == w_src);

      assign fwd_data[gi*DATA_W +: DATA_W] = w_fwd ? w_sdata : rd_rfdat[gi*DATA_W +: DATA_W];
      assign fwd_sel[gi*c_SELW +: c_SELW]  = w_fwd ? w_sel : '0;
      assign w_op_stall[gi] = w_hazard | (r_sb[w_src] & ~w_bypass);
      assign w_op_fwd[gi]   = w_fwd;
   end

   assign stall    = |w_op_stall;
   assign sb_busy  = r_sb;
   assign wdog_err = r_wdog_err;

   // Scoreboard: issue set is applied after completion clear so set wins;
   // register 0 is never tracked.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sb <= '0;
      end else begin
         if (cmp_en && (cmp_reg != '0)) r_sb[cmp_reg] <= 1'b0;
         if (iss_en && (iss_reg != '0)) r_sb[iss_reg] <= 1'b1;
      end
   end

   // Saturating consecutive-stall count, cleared by any non-stall cycle.
   always_comb begin
      w_cnt_nxt = 8'd0;
      if (stall) w_cnt_nxt = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
   end

   // Stall counter and sticky watchdog, flagged on the edge the count hits the limit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cnt <= 8'd0;
         r_wdog_err  <= 1'b0;
      end else begin
         r_stall_cnt <= w_cnt_nxt;
         if (stall && (w_cnt_nxt == c_wdog)) r_wdog_err <= 1'b1;
      end
   end

`ifdef FWD_PERF_EN
   logic [31:0] r_perf_fwd;
   logic [31:0] r_perf_stall;

   // Free-running wrap-around event counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_perf_fwd   <= 32'd0;
         r_perf_stall <= 32'd0;
      end else begin
         if (|w_op_fwd) r_perf_fwd   <= r_perf_fwd + 32'd1;
         if (stall)     r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_fwd   = r_perf_fwd;
   assign perf_stall = r_perf_stall;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = |w_op_fwd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Self-checking bench for fwd_hazard_unit (NREAD=2, NSTAGE=2,
//            WDOG=4). Expected outputs are queued when a cycle is driven and
//            popped and compared at the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

   localparam int NREAD  = 2;
   localparam int NSTAGE = 2;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int WDOG   = 4;

   localparam logic [31:0] c_RF0 = 32'hCAFE_0000;
   localparam logic [31:0] c_RF1 = 32'hCAFE_0001;

   logic                      CLK = 1'b0;
   logic                      RST;
   logic [NREAD*REG_W-1:0]    rd_reg;
   logic [NREAD*DATA_W-1:0]   rd_rfdat;
   logic [NSTAGE*REG_W-1:0]   st_dest;
   logic [NSTAGE-1:0]         st_wen;
   logic [NSTAGE-1:0]         st_valid;
   logic [NSTAGE*DATA_W-1:0]  st_data;
   logic                      iss_en;
   logic [REG_W-1:0]          iss_reg;
   logic                      cmp_en;
   logic [REG_W-1:0]          cmp_reg;
   logic [NREAD*DATA_W-1:0]   fwd_data;
   logic [3:0]                fwd_sel;
   logic                      stall;
   logic [31:0]               sb_busy;
   logic                      wdog_err;
`ifdef FWD_PERF_EN
   logic [31:0]               perf_fwd;
   logic [31:0]               perf_stall;
`endif

   // {data1, data0, sel1, sel0, stall}
   typedef logic [68:0] exp_t;
   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   fwd_hazard_unit #(
      .NREAD(NREAD), .NSTAGE(NSTAGE), .REG_W(REG_W), .DATA_W(DATA_W), .WDOG(WDOG)
   ) dut (
      .CLK(CLK), .RST(RST),
      .rd_reg(rd_reg), .rd_rfdat(rd_rfdat),
      .st_dest(st_dest), .st_wen(st_wen), .st_valid(st_valid), .st_data(st_data),
      .iss_en(iss_en), .iss_reg(iss_reg), .cmp_en(cmp_en), .cmp_reg(cmp_reg),
      .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .sb_busy(sb_busy),
`ifdef FWD_PERF_EN
      .perf_fwd(perf_fwd), .perf_stall(perf_stall),
`endif
      .wdog_err(wdog_err)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t mk(input logic [31:0] d1, input logic [31:0] d0,
                               input logic [1:0] s1, input logic [1:0] s0, input logic st);
      return {d1, d0, s1, s0, st};
   endfunction

   // Return all inputs to a quiet state.
   task automatic idle();
      rd_reg   = '0;
      rd_rfdat = {c_RF1, c_RF0};
      st_dest  = '0;
      st_wen   = '0;
      st_valid = '0;
      st_data  = '0;
      iss_en   = 1'b0;
      iss_reg  = '0;
      cmp_en   = 1'b0;
      cmp_reg  = '0;
   endtask

   // Queue the expectation for the cycle just driven and advance to the sample point.
   task automatic settle(input exp_t ex);
      q.push_back(ex);
      @(negedge CLK);
   endtask

   task automatic begin_cycle();
      @(posedge CLK);
      #1;
      idle();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      n_tests++;
      if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL reset_sb_busy got=%h exp=0", sb_busy); end
      n_tests++;
      if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL reset_wdog got=%b exp=0", wdog_err); end
   endtask

   task automatic test_priority();
      // Both stages write r5: youngest wins for operand 0; operand 1 reads r6 (no match).
      begin_cycle();
      rd_reg = {5'd6, 5'd5}; st_dest = {5'd5, 5'd5}; st_wen = 2'b11; st_valid = 2'b11;
      st_data = {32'h0000_BBBB, 32'h0000_AAAA};
      settle(mk(c_RF1, 32'h0000_AAAA, 2'd0, 2'd1, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL prio_youngest got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      // Only stage 1 writes; operand 1 matches stage 1 as well.
      begin_cycle();
      rd_reg = {5'd5, 5'd5}; st_dest = {5'd5, 5'd5}; st_wen = 2'b10; st_valid = 2'b11;
      st_data = {32'h0000_BBBB, 32'h0000_AAAA};
      settle(mk(32'h0000_BBBB, 32'h0000_BBBB, 2'd2, 2'd2, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL prio_stage1 got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      // Different operands hit different stages.
      begin_cycle();
      rd_reg = {5'd12, 5'd4}; st_dest = {5'd12, 5'd4}; st_wen = 2'b11; st_valid = 2'b11;
      st_data = {32'h1212_1212, 32'h0404_0404};
      settle(mk(32'h1212_1212, 32'h0404_0404, 2'd2, 2'd1, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL prio_split got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
   endtask

   task automatic test_load_use();
      // Nearest producer not valid: stall, do not fall back to older stage.
      begin_cycle();
      rd_reg = {5'd0, 5'd5}; st_dest = {5'd5, 5'd5}; st_wen = 2'b11; st_valid = 2'b10;
      st_data = {32'h0000_BBBB, 32'h0000_AAAA};
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b1));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL loaduse_stall got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      // Load has moved to stage 1 and returned.
      begin_cycle();
      rd_reg = {5'd0, 5'd5}; st_dest = {5'd5, 5'd0}; st_wen = 2'b10; st_valid = 2'b11;
      st_data = {32'h0000_1234, 32'h0};
      settle(mk(c_RF1, 32'h0000_1234, 2'd0, 2'd2, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL loaduse_resolve got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
   endtask

   task automatic test_r0();
      begin_cycle();
      rd_reg = '0; st_dest = '0; st_wen = 2'b11; st_valid = 2'b11;
      st_data = {32'h0000_FFFF, 32'h0000_FFFF};
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL r0_noforward got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      // A not-valid producer of r0 must not create a hazard either.
      begin_cycle();
      rd_reg = '0; st_dest = '0; st_wen = 2'b11; st_valid = 2'b00;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL r0_nohazard got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
   endtask

   task automatic test_scoreboard();
      begin_cycle();
      iss_en = 1'b1; iss_reg = 5'd9;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL sb_issue got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      for (int c = 0; c < 3; c++) begin
         begin_cycle();
         rd_reg = {5'd0, 5'd9};
         settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b1));
         e = q.pop_front(); n_tests++;
         if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL sb_stall_%0d got=%h exp=%h", c, {fwd_data, fwd_sel, stall}, e); end
      end
      n_tests++;
      if (sb_busy[9] !== 1'b1) begin n_fail++; $display("FAIL sb_busy9_set got=%b exp=1", sb_busy[9]); end
      // Completion cycle: bypass removes the stall.
      begin_cycle();
      rd_reg = {5'd0, 5'd9}; cmp_en = 1'b1; cmp_reg = 5'd9;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL sb_cmp_bypass got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      begin_cycle();
      rd_reg = {5'd0, 5'd9};
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL sb_after_cmp got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      n_tests++;
      if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL sb_busy_clear got=%h exp=0", sb_busy); end
   endtask

   task automatic test_same_cycle();
      begin_cycle();
      iss_en = 1'b1; iss_reg = 5'd7; cmp_en = 1'b1; cmp_reg = 5'd7;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front();
      begin_cycle();
      // Issue to r0 ignored; completion to non-busy r12 is a no-op.
      iss_en = 1'b1; iss_reg = 5'd0; cmp_en = 1'b1; cmp_reg = 5'd12;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front();
      n_tests++;
      if (sb_busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_set_wins got=%h exp=00000080", sb_busy); end
      begin_cycle();
      rd_reg = {5'd7, 5'd0};
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b1));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL sb_op1_stall got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      n_tests++;
      if (sb_busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_r0_ignored got=%h exp=00000080", sb_busy); end
      begin_cycle();
      cmp_en = 1'b1; cmp_reg = 5'd7;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front();
      begin_cycle();
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL sb_r7_clear got=%h exp=0", sb_busy); end
   endtask

   task automatic test_watchdog();
      begin_cycle();
      iss_en = 1'b1; iss_reg = 5'd3;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front();
      // At the sample point of stall cycle n, n-1 stall edges have passed.
      for (int n = 1; n <= 5; n++) begin
         begin_cycle();
         rd_reg = {5'd0, 5'd3};
         settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b1));
         e = q.pop_front(); n_tests++;
         if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL wd_stall_%0d got=%h exp=%h", n, {fwd_data, fwd_sel, stall}, e); end
         n_tests++;
         if (wdog_err !== (n >= 5)) begin n_fail++; $display("FAIL wd_err_%0d got=%b exp=%b", n, wdog_err, (n >= 5)); end
      end
      // Reset while still reading the busy register.
      begin_cycle();
      rd_reg = {5'd0, 5'd3}; RST = 1'b1;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b1));
      e = q.pop_front();
      begin_cycle();
      rd_reg = {5'd0, 5'd3}; RST = 1'b0;
      settle(mk(c_RF1, c_RF0, 2'd0, 2'd0, 1'b0));
      e = q.pop_front(); n_tests++;
      if ({fwd_data, fwd_sel, stall} !== e) begin n_fail++; $display("FAIL wd_rst_stall got=%h exp=%h", {fwd_data, fwd_sel, stall}, e); end
      n_tests++;
      if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wd_rst_err got=%b exp=0", wdog_err); end
      n_tests++;
      if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL wd_rst_sb got=%h exp=0", sb_busy); end
   endtask

   initial begin
      RST = 1'b1;
      idle();
      test_reset();
      test_priority();
      test_load_use();
      test_r0();
      test_scoreboard();
      test_same_cycle();
      test_watchdog();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand forwarding unit.
- Resolves N read operands in ID against M in-flight producer stages, nearest stage first.
- Adds a per-register scoreboard for variable-latency producers (mult/div, cache-miss loads) and generates the ID stall.
- Sits between the register file read and the ID/EX latch.

Parameters:
- NREAD, 2, number of source operands resolved per cycle.
- NSTAGE, 2, number of forwarding sources; index 0 = youngest (EX/MEM), NSTAGE-1 = oldest (MEM/WB).
- REG_W, 5, register index width; NREGS = 2**REG_W.
- DATA_W, 32, data width.
- WDOG, 255, stall-cycle watchdog limit (8-bit max).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- rd_reg  in  NREAD*REG_W  ID source register indices, operand i at [i*REG_W +: REG_W]
- rd_rfdat  in  NREAD*DATA_W  register-file read data per operand
- st_dest  in  NSTAGE*REG_W  producer destination per stage
- st_wen  in  NSTAGE  producer regWrite per stage
- st_valid  in  NSTAGE  producer data available this cycle (0 = load not yet returned)
- st_data  in  NSTAGE*DATA_W  producer result per stage
- iss_en  in  1  long-latency op issued this cycle
- iss_reg  in  REG_W  its destination
- cmp_en  in  1  long-latency op completes this cycle
- cmp_reg  in  REG_W  completing destination
- fwd_data  out  NREAD*DATA_W  resolved operand data
- fwd_sel  out  NREAD*($clog2(NSTAGE+1))  source: 0 = regfile, k = stage k-1
- stall  out  1  hold ID/IF this cycle
- sb_busy  out  NREGS  scoreboard state
- wdog_err  out  1  sticky: stall exceeded WDOG cycles

Behaviour:
- Clock/reset: single clock CLK; RST synchronous, active-high.
- Reset values: sb_busy=0, stall counter=0, wdog_err=0, perf counters=0. Combinational outputs follow inputs.
- Operand resolution (combinational, per operand i):
  - Pick the lowest stage k with st_wen[k]=1, st_dest[k]==rd_reg[i], rd_reg[i]!=0.
  - If found and st_valid[k]=1: fwd_data=st_data[k], fwd_sel=k+1.
  - If found and st_valid[k]=0: load-use hazard; fwd_data=rd_rfdat, fwd_sel=0, hazard_i=1. Older stages are NOT consulted.
  - If none found: fwd_data=rd_rfdat, fwd_sel=0.
  - Register 0 is never forwarded and never scoreboarded.
- Scoreboard (sequential):
  - iss_en sets sb_busy[iss_reg]; cmp_en clears sb_busy[cmp_reg].
  - Same register issued and completed in the same cycle: set wins.
  - Issue or complete to reg 0 is ignored.
  - Completion to a non-busy register is a no-op.
- Stall (combinational): stall = OR over i of (hazard_i | (sb_busy[rd_reg[i]] & ~cmp_bypass_i)).
  - cmp_bypass_i = cmp_en & cmp_reg==rd_reg[i]. The completing value arrives via a stage that cycle, so no stall.
- Stall counter: 8-bit, increments each cycle stall=1, clears on any stall=0 cycle, saturates at 255.
- Watchdog: when the counter reaches WDOG, wdog_err is set and held until RST.
- Reset mid-stall clears the scoreboard and counter next edge; stall drops once RST has been sampled.

Optional Feature:
- Macro FWD_PERF_EN.
- When defined, adds:
  - outputs perf_fwd (32b), count of cycles with ≥1 operand fwd_sel≠0;
  - perf_stall (32b), count of stall cycles.
  - Both wrap modulo 2**32 and reset to 0.
- When undefined, neither port nor counters exist.

Test Plan:
- Both stages write r5 (st_valid=1, data 0xAAAA at stage0, 0xBBBB at stage1), rd_reg0=5 -> fwd_data0=0xAAAA, fwd_sel0=1, stall=0.
- Stage0 writes r5 with st_valid=0, stage1 writes r5 valid 0xBBBB -> stall=1, fwd_sel0=0. Next cycle stage1 valid 0x1234 -> fwd_data0=0x1234, stall=0.
- rd_reg=0, all stages write r0 with 0xFFFF -> fwd_data=rd_rfdat, fwd_sel=0, stall=0.
- iss_en r9; read r9 for 3 cycles -> stall=1 each cycle. cmp_en r9 in cycle 4 -> stall=0 that cycle, sb_busy[9]=0 next cycle.
- Same cycle iss_en r7 and cmp_en r7 -> sb_busy[7]=1 after the edge.
- iss_en r3 never completed, read r3, WDOG=4 -> wdog_err=1 after the 4th stall cycle. Assert RST -> wdog_err=0, sb_busy=0, stall=0.
